// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the serial adder: FSM state encoding, a
// one-bit full-adder cell and a ceil-log2 used to size the digit counter.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic ci);
    return {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
  endfunction

  // ceil(log2(value)), never less than 1 so a counter always has a bit.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder; master drives operands, slave returns the sum.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic             cy;
  logic             ovf;

  modport master (
    output start, A, B, cin,
    input  busy, done, out, cy, ovf
  );

  modport slave (
    input  start, A, B, cin,
    output busy, done, out, cy, ovf
  );
endinterface

// File: rtl/serial_adder_digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder; c_msb is the carry into the top bit,
// which on the last digit of a word is the carry into the word's sign bit.
module digit_adder
  import serial_adder_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             c_msb
);
  always_comb begin
    logic       c;
    logic [1:0] fa;
    s     = '0;
    c     = ci;
    c_msb = ci;
    fa    = '0;
    for (int i = 0; i < DIGIT; i++) begin
      c_msb = c;
      fa    = full_add(a[i], b[i], c);
      s[i]  = fa[0];
      c     = fa[1];
    end
    co = c;
  end
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: DIGIT bits of A+B+cin per clock, LSB first; done pulses WIDTH/DIGIT+1 cycles after start.
// start is taken only in IDLE or DONE (back-to-back without a gap); starts while busy are dropped.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic           clk,
  input logic           rst,
  serial_adder_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = clog2_min1(N + 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [WIDTH-1:0] out_q;
  logic             carry;
  logic             cy_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] dsum;
  logic             dco;
  logic             dcmsb;
  logic             last_step;

  digit_adder #(.DIGIT(DIGIT)) u_digit (
    .a     (a_sh[DIGIT-1:0]),
    .b     (b_sh[DIGIT-1:0]),
    .ci    (carry),
    .s     (dsum),
    .co    (dco),
    .c_msb (dcmsb)
  );

  // New digit enters at the top so that after N steps the LSB digit sits at bit 0.
  assign res_next  = (res_sh >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
  assign last_step = (cnt == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      out_q  <= '0;
      cy_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            a_sh   <= bus.A;
            b_sh   <= bus.B;
            carry  <= bus.cin;
            res_sh <= '0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= S_RUN;
          end else begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          res_sh <= res_next;
          carry  <= dco;
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            out_q  <= res_next;
            cy_q   <= dco;
            ovf_q  <= dcmsb ^ dco;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;
  assign bus.cy   = cy_q;
  assign bus.ovf  = ovf_q;
endmodule
